cu_sequencer: RTL
=================

# cu_sequencer

Parametrised, state-machine-based successor to the CPU control unit. It sequences instruction fetch and execute for the 8-bit accumulator CPU and drives all datapath strobes. It adds an explicit FETCH/EXEC/ST_WRITE/HALTED FSM, one-hot register enables sized by parameter, a memory wait-state handshake, a HALT instruction and illegal-opcode reporting. It sits between the instruction register/flags and the register file, ALU and memory bus.

## Interface
- NREG, 4, register count (2..4); index 0 is accumulator A
- NFLAG, 4, number of ALU flags tested by Jc (2..4)
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous reset, active low
- ir  in  8  current instruction (from IR)
- flags  in  NFLAG  stored ALU flags
- mem_ready  in  1  memory access completes this cycle (used only with CU_MEM_WAIT_EN)
- mem_oe, mem_we  out  1  memory read / write strobe, active high
- addr_dp  out  1  0: address = IP, 1: address = DP
- ir_we  out  1  latch D into IR at posedge
- ip_inc  out  1  increment IP at posedge
- swap_p  out  1  swap IP/DP at posedge
- d_to_di  out  1  drive D bus onto DI
- reg_we  out  NREG  one-hot register write enable from DI
- a_we  out  1  accumulator write enable (ALU result to A)
- reg_oe_alu  out  NREG  one-hot ALU-B source; bit 0 means constant zero
- oe_a_d, oe_b_d  out  1  drive D bus with A / B
- alu_oe, alu_invert, we_flags  out  1  ALU result to DI, invert operands, latch flags
- halted  out  1  FSM in HALTED
- illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- Encoding: ALU 0oooo i dd; LD 1000__dd; LDI 1010__dd; ST 1011___s; Jc 11000cff; JMP 11001___; HALT 1110____; 1001xxxx, 1101xxxx and 1111xxxx are undefined.
- accept = mem_ready (with macro) or 1 (without). Every memory-access state holds its outputs until accept.
- FETCH: addr_dp=0, mem_oe=1, ir_we=1, ip_inc=accept. On accept go to EXEC.
- EXEC, by class:
  - ALU, one cycle: alu_oe=1, we_flags=1, reg_oe_alu=onehot(dd). If i=0, a_we=1. If i=1, reg_we=onehot(dd) and alu_invert=1.
  - LD: addr_dp=1, mem_oe=1, d_to_di=1, reg_we=onehot(dd) gated by accept.
  - LDI: addr_dp=0, mem_oe=1, d_to_di=1, reg_we=onehot(dd) and ip_inc gated by accept.
  - ST: addr_dp=1, oe_a_d=~s, oe_b_d=s, mem_we=0 (address/data setup). Go to ST_WRITE.
  - Jc/JMP: swap_p = ir[3] | (ir[2] ^ flags[ff]). ff ≥ NFLAG reads 0.
  - HALT: go to HALTED.
  - Undefined: illegal=1, no strobes (NOP).
  - Every class except ST and HALT returns to FETCH after its accept.
- ST_WRITE: addr_dp=1, mem_we=1, D driven as in EXEC. On accept go to FETCH.
- HALTED: all strobes 0, halted=1. Only rst leaves this state.
- dd ≥ NREG: reg_we/reg_oe_alu are all-zero and illegal pulses.

## Timing
- rst=0 at posedge puts the FSM in FETCH. While rst=0, every output is forced to 0. First fetch strobes appear in the cycle after release.
- Outputs are combinational from state, ir, flags and accept. Datapath samples strobes at the next posedge.
- Latency (no waits):
  - ALU, LD, LDI, Jc, JMP, undefined: 2 cycles (FETCH+EXEC).
  - ST: 3 cycles.
  - HALT: 2 cycles to HALTED.
- Wait states extend only the waiting state. Gated strobes (ip_inc, reg_we, ir_we edge) take effect exactly once, at the accepting posedge.
- Reset during ST_WRITE or mid-wait aborts the access; mem_we drops in the reset cycle.
- ir is sampled only in EXEC/ST_WRITE and must be stable there.

## Configuration
- CU_MEM_WAIT_EN defined: mem_ready gates all memory states as above.
- Undefined: mem_ready is ignored and accept=1. Every memory state lasts exactly one cycle.

## Structure
- Package cu_pkg:
  - state enum (FETCH, EXEC, ST_WRITE, HALTED)
  - opcode-class enum (ALU, LD, LDI, ST, JMP, HALT, ILLEGAL)
  - IR field position constants
- Sub-module cu_decode: combinational ir → class, dd, s, i, condition fields.
- FSM and output logic live in cu_sequencer.

## Test plan
- Reset: rst=0 for 2 cycles → all outputs 0. After release, cycle 1 shows mem_oe=1, ir_we=1, addr_dp=0, ip_inc=1.
- ALU: ir=0x05 (i=1, dd=01) → EXEC: reg_we=0010, reg_oe_alu=0010, alu_invert=1, we_flags=1, then FETCH. ir=0x01 → a_we=1, reg_we=0000.
- ST: ir=0xB1 → EXEC: oe_b_d=1, mem_we=0. ST_WRITE: mem_we=1, addr_dp=1. Total 3 cycles.
- Jc: ir=0xC2, flags=0100 → swap_p=1. ir=0xC6, same flags → swap_p=0. ir=0xC8 → swap_p=1.
- Waits (macro on): LD with mem_ready low for 3 cycles → reg_we asserted but only the 4th posedge commits. ip_inc during FETCH wait occurs once.
- HALT/illegal: ir=0xE0 → halted=1, stays for 10 cycles until rst. ir=0x90 → illegal pulse for 1 cycle, no strobes, then FETCH.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and IR field positions for the accumulator-CPU control unit.
package cu_pkg;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_EXEC     = 2'd1,
    S_ST_WRITE = 2'd2,
    S_HALTED   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LD      = 3'd1,
    CL_LDI     = 3'd2,
    CL_ST      = 3'd3,
    CL_JMP     = 3'd4,
    CL_HALT    = 3'd5,
    CL_ILLEGAL = 3'd6
  } op_class_e;

  // IR field positions
  localparam int IR_CLASS_BIT  = 7;  // 0: ALU instruction
  localparam int IR_MAJOR_MSB  = 6;  // ir[6:4] selects the non-ALU class
  localparam int IR_MAJOR_LSB  = 4;
  localparam int IR_UNCOND_BIT = 3;  // JMP vs Jc
  localparam int IR_I_BIT      = 2;  // ALU: write to register dd with inverted operands
  localparam int IR_C_BIT      = 2;  // Jc: invert the tested flag
  localparam int IR_FIELD_MSB  = 1;  // dd / ff field
  localparam int IR_FIELD_LSB  = 0;
  localparam int IR_S_BIT      = 0;  // ST: 0 stores A, 1 stores B

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decoder: IR -> opcode class and operand fields.
module cu_decode
  import cu_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic [7:0]      ir,
  output op_class_e       op_class,
  output logic            i_bit,
  output logic            s_bit,
  output logic            c_bit,
  output logic            uncond,
  output logic [1:0]      ff,
  output logic [NREG-1:0] reg_onehot,
  output logic            dd_bad
);

  logic [1:0] dd;

  assign dd     = ir[IR_FIELD_MSB:IR_FIELD_LSB];
  assign ff     = ir[IR_FIELD_MSB:IR_FIELD_LSB];
  assign i_bit  = ir[IR_I_BIT];
  assign c_bit  = ir[IR_C_BIT];
  assign s_bit  = ir[IR_S_BIT];
  assign uncond = ir[IR_UNCOND_BIT];

  // Classify the opcode; every unlisted high nibble is undefined.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    op_class = CL_ILLEGAL;
    if (!ir[IR_CLASS_BIT]) begin
      op_class = CL_ALU;
    end else begin
      case (ir[IR_MAJOR_MSB:IR_MAJOR_LSB])
        3'b000:  op_class = CL_LD;
        3'b010:  op_class = CL_LDI;
        3'b011:  op_class = CL_ST;
        3'b100:  op_class = CL_JMP;
        3'b110:  op_class = CL_HALT;
        default: op_class = CL_ILLEGAL;
      endcase
    end
  end

  // One-hot register select; indices beyond the register file give all-zero.
  always_comb begin
    reg_onehot = '0;
    dd_bad     = (int'(dd) >= NREG);
    for (int k = 0; k < NREG; k++) begin
      if (int'(dd) == k) reg_onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/cu_sequencer.sv
// FETCH/EXEC/ST_WRITE/HALTED sequencer for the 8-bit accumulator CPU.
// Build option: define CU_MEM_WAIT_EN to let mem_ready stretch memory states;
// otherwise every memory access completes in one cycle and mem_ready is ignored.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int NREG  = 4,
  parameter int NFLAG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ir,
  input  logic [NFLAG-1:0] flags,
  input  logic             mem_ready,
  output logic             mem_oe,
  output logic             mem_we,
  output logic             addr_dp,
  output logic             ir_we,
  output logic             ip_inc,
  output logic             swap_p,
  output logic             d_to_di,
  output logic [NREG-1:0]  reg_we,
  output logic             a_we,
  output logic [NREG-1:0]  reg_oe_alu,
  output logic             oe_a_d,
  output logic             oe_b_d,
  output logic             alu_oe,
  output logic             alu_invert,
  output logic             we_flags,
  output logic             halted,
  output logic             illegal
);

  state_e          state_q, state_d;
  op_class_e       op_class;
  logic            i_bit, s_bit, c_bit, uncond, dd_bad;
  logic [1:0]      ff;
  logic [NREG-1:0] reg_onehot;
  logic            accept;
  logic            flag_bit;

`ifdef CU_MEM_WAIT_EN
  assign accept = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign accept           = 1'b1;
`endif

  cu_decode #(.NREG(NREG)) u_decode (
    .ir         (ir),
    .op_class   (op_class),
    .i_bit      (i_bit),
    .s_bit      (s_bit),
    .c_bit      (c_bit),
    .uncond     (uncond),
    .ff         (ff),
    .reg_onehot (reg_onehot),
    .dd_bad     (dd_bad)
  );

  // Select the tested flag; indices past the flag vector read as zero.
  always_comb begin
    flag_bit = 1'b0;
    for (int k = 0; k < NFLAG; k++) begin
      if (int'(ff) == k) flag_bit = flags[k];
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state and strobe decode; everything is held low while reset is asserted.
  always_comb begin
    state_d    = state_q;
    mem_oe     = 1'b0;
    mem_we     = 1'b0;
    addr_dp    = 1'b0;
    ir_we      = 1'b0;
    ip_inc     = 1'b0;
    swap_p     = 1'b0;
    d_to_di    = 1'b0;
    reg_we     = '0;
    a_we       = 1'b0;
    reg_oe_alu = '0;
    oe_a_d     = 1'b0;
    oe_b_d     = 1'b0;
    alu_oe     = 1'b0;
    alu_invert = 1'b0;
    we_flags   = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          mem_oe = 1'b1;
          ir_we  = 1'b1;
          ip_inc = accept;
          if (accept) state_d = S_EXEC;
        end
        S_EXEC: begin
          case (op_class)
            CL_ALU: begin
              alu_oe     = 1'b1;
              we_flags   = 1'b1;
              reg_oe_alu = reg_onehot;
              illegal    = dd_bad;
              if (i_bit) begin
                reg_we     = reg_onehot;
                alu_invert = 1'b1;
              end else begin
                a_we = 1'b1;
              end
              state_d = S_FETCH;
            end
            CL_LD, CL_LDI: begin
              // LD reads through DP; LDI reads the immediate at IP and steps past it.
              addr_dp = (op_class == CL_LD);
              mem_oe  = 1'b1;
              d_to_di = 1'b1;
              if (accept) begin
                reg_we  = reg_onehot;
                ip_inc  = (op_class == CL_LDI);
                illegal = dd_bad;
                state_d = S_FETCH;
              end
            end
            CL_ST: begin
              addr_dp = 1'b1;
              oe_a_d  = ~s_bit;
              oe_b_d  = s_bit;
              state_d = S_ST_WRITE;
            end
            CL_JMP: begin
              swap_p  = uncond | (c_bit ^ flag_bit);
              state_d = S_FETCH;
            end
            CL_HALT: state_d = S_HALTED;
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_ST_WRITE: begin
          addr_dp = 1'b1;
          mem_we  = 1'b1;
          oe_a_d  = ~s_bit;
          oe_b_d  = s_bit;
          if (accept) state_d = S_FETCH;
        end
        S_HALTED: halted = 1'b1;
        default:  state_d = S_FETCH;
      endcase
    end
  end

endmodule
